// File: rtl/ds1302_pkg.sv
// ds1302_pkg: shared types and constants for the DS1302 3-wire serial engine.
// Contents: FSM state enum, common DS1302 command bytes, bit count per frame,
// and a small max helper used to size the shared timing counter.
package ds1302_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    HIGH,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] SEC_WR  = 8'h80;
  localparam logic [7:0] SEC_RD  = 8'h81;
  localparam logic [7:0] MIN_RD  = 8'h83;
  localparam logic [7:0] HOUR_RD = 8'h85;
  localparam logic [7:0] CTRL_WR = 8'h8E;

  localparam int BIT_COUNT = 16;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ds1302_serial_if_if.sv
// ds1302_cmd_if: command/response handshake between the RTC register
// sequencer (master) and the serial engine (slave).
// Signals: cmd_valid/cmd_ready/cmd_addr/cmd_wdata, rsp_valid/rsp_rdata.
interface ds1302_cmd_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/ds1302_io_sync.sv
// ds1302_io_sync: 2-flop synchronizer for the DS1302 IO pin input.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronized out).
// Only compiled when DS1302_IO_SYNC_EN is defined, so the default build has no orphan module.
`ifdef DS1302_IO_SYNC_EN
module ds1302_io_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule
`endif

// File: rtl/ds1302_serial_if.sv
// ds1302_serial_if: bit-level CE/SCLK/IO engine for the DS1302 RTC; one command byte
// (+ write byte) per transaction, LSB first, read byte returned on rsp_valid.
// Ports: clk, rst_n (async active-low), cmd (ds1302_cmd_if.slave), ds_ce/ds_sclk/ds_io_out/ds_io_oe out, ds_io_in in.
// Macro DS1302_IO_SYNC_EN: route ds_io_in through a 2-flop synchronizer (needs CLK_DIV>=3).
module ds1302_serial_if
  import ds1302_pkg::*;
#(
  parameter int CLK_DIV  = 50,
  parameter int CE_SETUP = 200,
  parameter int CE_HOLD  = 50,
  parameter int CE_GAP   = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  ds1302_cmd_if.slave  cmd,
  output logic         ds_ce,
  output logic         ds_sclk,
  output logic         ds_io_out,
  output logic         ds_io_oe,
  input  logic         ds_io_in
);

  localparam int CNT_MAX = max4(CLK_DIV, CE_SETUP, CE_HOLD, CE_GAP);
  localparam int CW      = $clog2(CNT_MAX);

  // Counters count down from length-1 to 0 within each timed state.
  localparam logic [CW-1:0] SETUP_LD = CW'(CE_SETUP - 1);
  localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CE_HOLD - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(CE_GAP - 1);
  localparam logic [3:0]    LAST_BIT = 4'(BIT_COUNT - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [3:0]      bit_idx, bit_nxt;
  logic [15:0]     tx, tx_nxt;
  logic            rd, rd_nxt;
  logic [7:0]      rx;
  logic            capture;
  logic            rsp_nxt;
  logic            ce_nxt, sclk_nxt, io_out_nxt, oe_nxt;
  logic            io_smp;

`ifdef DS1302_IO_SYNC_EN
  ds1302_io_sync u_io_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ds_io_in),
    .q     (io_smp)
  );
`else
  assign io_smp = ds_io_in;
`endif

  assign cmd.cmd_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    rd_nxt    = rd;
    capture   = 1'b0;
    rsp_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          state_nxt = SETUP;
          cnt_nxt   = SETUP_LD;
          bit_nxt   = 4'd0;
          rd_nxt    = cmd.cmd_addr[0];
          // Reads shift out zeros in the data half; the pin is released anyway.
          tx_nxt    = {(cmd.cmd_addr[0] ? 8'h00 : cmd.cmd_wdata), cmd.cmd_addr};
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = LOW;
          cnt_nxt   = DIV_LD;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      LOW: begin
        if (cnt == '0) begin
          state_nxt = HIGH;
          cnt_nxt   = DIV_LD;
          // Sample on the rising SCLK edge of the data half.
          capture   = bit_idx[3];
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          cnt_nxt = DIV_LD;
          if (bit_idx == LAST_BIT) begin
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LD;
          end else begin
            state_nxt = LOW;
            bit_nxt   = bit_idx + 4'd1;
          end
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
          rsp_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Pin values are registered from the next state so they change together with it.
    ce_nxt   = (state_nxt == SETUP) || (state_nxt == LOW) ||
               (state_nxt == HIGH)  || (state_nxt == HOLD);
    sclk_nxt = (state_nxt == HIGH);
    // Reads hand the pin to the chip from the LOW of bit 8 onwards.
    oe_nxt   = ce_nxt && (!rd_nxt || !bit_nxt[3]);

    io_out_nxt = ds_io_out;
    if (!ce_nxt) begin
      io_out_nxt = 1'b0;
    end else if ((state_nxt == LOW) && (state != LOW)) begin
      io_out_nxt = tx_nxt[bit_nxt];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= 4'd0;
      tx            <= 16'h0000;
      rd            <= 1'b0;
      rx            <= 8'h00;
      ds_ce         <= 1'b0;
      ds_sclk       <= 1'b0;
      ds_io_out     <= 1'b0;
      ds_io_oe      <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_nxt;
      tx        <= tx_nxt;
      rd        <= rd_nxt;
      ds_ce     <= ce_nxt;
      ds_sclk   <= sclk_nxt;
      ds_io_out <= io_out_nxt;
      ds_io_oe  <= oe_nxt;
      if (capture) begin
        rx[bit_idx[2:0]] <= io_smp;
      end
      cmd.rsp_valid <= rsp_nxt;
      if (rsp_nxt) begin
        cmd.rsp_rdata <= rd ? rx : 8'h00;
      end
    end
  end

endmodule
